// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, add/subtract ALU, immediate sign-extender, data memory.
// Optional status flags are built only when BIP_FLAGS_EN is defined; otherwise flag outputs are tied low.
module bip_datapath #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] operand,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [1:0]        SelA,
  input  logic              SelB,
  input  logic              WrAcc,
  input  logic              Op,
  input  logic              WrRam,
  input  logic              RdRam,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v
);

  localparam int IDX_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam int MSB   = DATA_W - 1;

  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] acc_src;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       addr_ext;
  logic              in_range;
  logic              acc_load;
  logic              dmem_we;

  assign imm      = {{(DATA_W-ADDR_W){operand[ADDR_W-1]}}, operand};
  assign addr_ext = 32'(data_address);
  assign in_range = addr_ext < 32'(DMEM_DEPTH);
  assign mem_idx  = data_address[IDX_W-1:0];

  assign mem_rdata = (RdRam && in_range) ? dmem[mem_idx] : '0;

  assign alu_b   = SelB ? imm : mem_rdata;
  assign alu_res = Op ? (acc - alu_b) : (acc + alu_b);

  always_comb begin
    acc_src = acc;
    unique case (SelA)
      2'b00:   acc_src = mem_rdata;
      2'b01:   acc_src = imm;
      2'b10:   acc_src = alu_res;
      default: acc_src = acc;
    endcase
  end

  assign acc_load = WrAcc && (SelA != 2'b11);
  assign dmem_we  = WrRam && in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (acc_load) begin
      acc <= acc_src;
    end
  end

  // Memory is never cleared; rst in the sensitivity list only blocks a store on a reset edge.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && dmem_we) begin
      dmem[mem_idx] <= acc;
    end
  end

`ifdef BIP_FLAGS_EN
  logic alu_ovf;

  always_comb begin
    if (Op) begin
      alu_ovf = (acc[MSB] != alu_b[MSB]) && (alu_res[MSB] != acc[MSB]);
    end else begin
      alu_ovf = (acc[MSB] == alu_b[MSB]) && (alu_res[MSB] != acc[MSB]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (acc_load) begin
      flag_z <= (acc_src == '0);
      flag_n <= acc_src[MSB];
      flag_v <= (SelA == 2'b10) && alu_ovf;
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_bip_datapath.sv
// Directed bench for bip_datapath: integer-arithmetic reference model checked every cycle,
// plus literal expectations at key points of the instruction sequence.
module tb_bip_datapath;

  logic        clk;
  logic        rst;
  logic [10:0] operand;
  logic [10:0] data_address;
  logic [1:0]  SelA;
  logic        SelB;
  logic        WrAcc;
  logic        Op;
  logic        WrRam;
  logic        RdRam;
  logic [15:0] acc;
  logic [15:0] mem_rdata;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;

  int errors = 0;
  int checks = 0;

  bip_datapath #(.DATA_W(16), .ADDR_W(11), .DMEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .operand(operand), .data_address(data_address),
    .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc), .Op(Op), .WrRam(WrRam), .RdRam(RdRam),
    .acc(acc), .mem_rdata(mem_rdata), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integers, two's-complement by truncation, memory as a sparse map.
  logic [15:0] m_acc = 16'h0;
  logic        m_z = 1'b0;
  logic        m_n = 1'b0;
  logic        m_v = 1'b0;
  logic [15:0] mem_m [int];

  function automatic int sgn(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic bit model_rd(output logic [15:0] v);
    v = 16'h0;
    if (!RdRam || int'(data_address) >= 1024) return 1'b1;
    if (!mem_m.exists(int'(data_address))) return 1'b0;
    v = mem_m[int'(data_address)];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int imm_s, sa, sb, r_s;
    logic [15:0] rd, nv;
    bit ok;
    if (!rst) begin
      m_acc = 16'h0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    end else begin
      ok    = model_rd(rd);
      imm_s = operand[10] ? int'(operand) - 2048 : int'(operand);
      sa    = sgn(m_acc);
      sb    = SelB ? imm_s : sgn(rd);
      r_s   = Op ? sa - sb : sa + sb;
      case (SelA)
        2'b00:   nv = rd;
        2'b01:   nv = 16'(imm_s);
        2'b10:   nv = 16'(r_s);
        default: nv = m_acc;
      endcase
      if (WrRam && int'(data_address) < 1024) mem_m[int'(data_address)] = m_acc;
      if (WrAcc && SelA != 2'b11) begin
        m_acc = nv;
`ifdef BIP_FLAGS_EN
        m_z = (nv == 16'h0);
        m_n = (int'(nv) >= 32768);
        m_v = (SelA == 2'b10) && (r_s > 32767 || r_s < -32768);
`endif
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] rd;
    chk("model_acc", acc, m_acc);
    chk("model_flag_z", {15'h0, flag_z}, {15'h0, m_z});
    chk("model_flag_n", {15'h0, flag_n}, {15'h0, m_n});
    chk("model_flag_v", {15'h0, flag_v}, {15'h0, m_v});
    if (model_rd(rd)) chk("model_mem_rdata", mem_rdata, rd);
  end

  task automatic set_in(input logic [1:0] sa, input logic sb, input logic wa, input logic op,
                        input logic wr, input logic rr, input logic [10:0] opnd,
                        input logic [10:0] addr);
    SelA = sa; SelB = sb; WrAcc = wa; Op = op; WrRam = wr; RdRam = rr;
    operand = opnd; data_address = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ldi(input logic [10:0] v);  set_in(2'b01, 0, 1, 0, 0, 0, v, 11'd0); tick(); endtask
  task automatic addi(input logic [10:0] v); set_in(2'b10, 1, 1, 0, 0, 0, v, 11'd0); tick(); endtask
  task automatic subi(input logic [10:0] v); set_in(2'b10, 1, 1, 1, 0, 0, v, 11'd0); tick(); endtask
  task automatic sto(input logic [10:0] a);  set_in(2'b00, 0, 0, 0, 1, 0, 11'd0, a); tick(); endtask
  task automatic ld(input logic [10:0] a);   set_in(2'b00, 0, 1, 0, 0, 1, 11'd0, a); tick(); endtask
  task automatic add(input logic [10:0] a);  set_in(2'b10, 0, 1, 0, 0, 1, 11'd0, a); tick(); endtask
  task automatic nop();                      set_in(2'b00, 0, 0, 0, 0, 0, 11'd0, 11'd0); tick(); endtask

  initial begin
    rst = 1'b0;
    set_in(2'b01, 0, 1, 0, 0, 0, 11'd5, 11'd0);
    #1;
    chk("reset_acc_immediate", acc, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_acc_held", acc, 16'h0);
    end
    rst = 1'b1;
    tick();
    chk("release_ldi5", acc, 16'h0005);

    ldi(11'd7);   chk("ldi7", acc, 16'h0007);
    addi(11'd3);  chk("addi3", acc, 16'h000A);
    subi(11'd12); chk("subi12", acc, 16'hFFFE);
`ifdef BIP_FLAGS_EN
    chk("subi12_flag_n", {15'h0, flag_n}, 16'h1);
    chk("subi12_flag_z", {15'h0, flag_z}, 16'h0);
`endif

    ldi(11'h7FF); chk("sext_7ff", acc, 16'hFFFF);
    ldi(11'h400); chk("sext_400", acc, 16'hFC00);

    set_in(2'b01, 0, 0, 0, 0, 0, 11'd3, 11'd0); tick();
    chk("wracc0_hold", acc, 16'hFC00);
    set_in(2'b11, 0, 1, 0, 0, 0, 11'd3, 11'd0); tick();
    chk("sela11_hold", acc, 16'hFC00);

    // Build 0x1234: 0x234 minus four sign-extended -1024 steps.
    ldi(11'h234);
    for (int i = 0; i < 4; i++) subi(11'h400);
    chk("build_1234", acc, 16'h1234);
    sto(11'd3);
    set_in(2'b00, 0, 1, 0, 0, 1, 11'd0, 11'd3);
    #1;
    chk("ld3_rdata", mem_rdata, 16'h1234);
    tick();
    chk("ld3_acc", acc, 16'h1234);
    add(11'd3);   chk("add3", acc, 16'h2468);
    set_in(2'b00, 0, 0, 0, 0, 0, 11'd0, 11'd3);
    #1;
    chk("rdram0_zero", mem_rdata, 16'h0);
    tick();

    ldi(11'd9);
    set_in(2'b01, 0, 1, 0, 1, 0, 11'd1, 11'd4); tick();
    chk("wr_both_acc", acc, 16'h0001);
    ld(11'd4);    chk("wr_both_mem", acc, 16'h0009);

    ldi(11'h055); sto(11'd0);
    ldi(11'h066); sto(11'd1024);
    set_in(2'b00, 0, 0, 0, 0, 1, 11'd0, 11'd1024);
    #1;
    chk("oor_rdata", mem_rdata, 16'h0);
    tick();
    ld(11'd0);    chk("oor_no_alias", acc, 16'h0055);

    // Read and write of the same word in one cycle: ALU sees the old word.
    ldi(11'h077);
    set_in(2'b10, 0, 1, 0, 1, 1, 11'd0, 11'd4); tick();
    chk("rw_same_acc", acc, 16'h0080);
    ld(11'd4);    chk("rw_same_mem", acc, 16'h0077);

    ldi(11'h200);
    for (int i = 0; i < 6; i++) begin
      sto(11'd5);
      add(11'd5);
    end
    chk("double_8000", acc, 16'h8000);
    subi(11'd1);  chk("subi1_7fff", acc, 16'h7FFF);
`ifdef BIP_FLAGS_EN
    chk("sub_ovf_v", {15'h0, flag_v}, 16'h1);
`endif
    addi(11'd1);  chk("addi1_8000", acc, 16'h8000);
`ifdef BIP_FLAGS_EN
    chk("add_ovf_v", {15'h0, flag_v}, 16'h1);
    chk("add_ovf_n", {15'h0, flag_n}, 16'h1);
`endif
    ldi(11'd0);
    subi(11'd0);  chk("subi0_acc", acc, 16'h0);
`ifdef BIP_FLAGS_EN
    chk("subi0_z", {15'h0, flag_z}, 16'h1);
    chk("subi0_v", {15'h0, flag_v}, 16'h0);
`endif

    // Reset asserted mid-instruction discards both the acc load and the store.
    ldi(11'h011); sto(11'd6);
    set_in(2'b01, 0, 1, 0, 1, 0, 11'h022, 11'd6);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_acc", acc, 16'h0);
    tick();
    rst = 1'b1;
    nop();
    chk("midreset_after", acc, 16'h0);
    ld(11'd6);    chk("midreset_mem", acc, 16'h0011);
    nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bip_datapath.md
# bip_datapath

Execution datapath of the BIP processor, directly downstream of the control unit. Consumes the control unit's decoded strobes (SelA, SelB, WrAcc, Op, WrRam, RdRam), its data_address, and the 11-bit operand field of the current instruction. Holds the accumulator, the add/subtract ALU, the operand sign-extender and the on-chip data memory. Completes one instruction per clock, in lockstep with the control unit's program counter.

## Interface
- DATA_W, 16, accumulator / memory word width
- ADDR_W, 11, data address and operand width
- DMEM_DEPTH, 1024, number of data-memory words implemented (≤ 2^ADDR_W)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- operand  in  ADDR_W  instruction[10:0], immediate field
- data_address  in  ADDR_W  data-memory address from control
- SelA  in  2  accumulator source: 00 memory, 01 sign-extended immediate, 10 ALU result, 11 hold
- SelB  in  1  ALU B operand: 0 memory, 1 sign-extended immediate
- WrAcc  in  1  load accumulator from SelA source
- Op  in  1  ALU operation: 0 add (A+B), 1 subtract (A−B)
- WrRam  in  1  write accumulator to dmem[data_address]
- RdRam  in  1  enable memory read path
- acc  out  DATA_W  accumulator
- mem_rdata  out  DATA_W  current memory read value (debug/observe)
- flag_z, flag_n, flag_v  out  1  zero/negative/overflow (see Configuration)

## Operation
- imm = operand sign-extended to DATA_W (operand[10] replicated).
- mem_rdata = dmem[data_address] when RdRam=1 and data_address < DMEM_DEPTH, else 0. Combinational read.
- ALU: A = acc, B = SelB ? imm : mem_rdata; result = Op ? A−B : A+B, modulo 2^DATA_W.
- On rising clk with WrAcc=1: acc <= source per SelA; SelA=11 leaves acc unchanged. WrAcc=0: acc holds regardless of SelA.
- On rising clk with WrRam=1 and data_address < DMEM_DEPTH: dmem[data_address] <= acc (pre-edge value). Out-of-range writes are dropped silently.
- BIP opcode mapping (produced by control): STO = WrRam; LD = SelA 00, RdRam; LDI = SelA 01; ADD/SUB = SelA 10, SelB 0, RdRam; ADDI/SUBI = SelA 10, SelB 1; HLT/NOP = all strobes 0.
- Inconsistent strobes are not errors: block executes them literally.

## Timing
- Reset (rst=0, asynchronous): acc=0, flags=0 immediately; dmem contents not reset (undefined after power-up); no writes while rst=0.
- Release of rst is sampled on the next rising edge; first update on the first edge with rst=1.
- Latency: strobes presented in cycle N are reflected in acc / dmem after edge ending cycle N (1 cycle). mem_rdata and ALU result are combinational, 0 cycles.
- WrRam and WrAcc in the same cycle: memory stores the old acc; acc takes its new value.
- Read and write of the same address in the same cycle: mem_rdata and ALU see the old word; new word visible the following cycle.
- Back-to-back STO then LD to same address: LD returns the stored value (no hazard; write completes at edge before LD cycle).
- Reset asserted mid-instruction: pending acc/dmem write for that cycle is discarded.

## Configuration
- BIP_FLAGS_EN defined: flag registers update on every edge with WrAcc=1 and SelA≠11, from the value loaded into acc: flag_z = (new acc==0), flag_n = new acc[DATA_W−1], flag_v = signed overflow of the ALU when SelA=10 (add: A,B same sign and result sign differs; sub: A,B signs differ and result sign ≠ A sign), else 0. Flags hold otherwise.
- BIP_FLAGS_EN undefined: no flag registers; flag_z, flag_n, flag_v tied to 0.

## Test plan
- Reset: drive rst=0 with WrAcc=1, SelA=01, operand=5 -> acc=0 throughout; release rst, next edge -> acc=5.
- LDI 7, ADDI 3, SUBI 12 (SelB=1, Op 0/1) -> acc 7, 10, 16'hFFFE; with BIP_FLAGS_EN flag_n=1, flag_z=0.
- Sign extension: LDI operand 11'h7FF -> acc 16'hFFFF; LDI 11'h400 -> 16'hFC00.
- STO to address 3 with acc=16'h1234, then LD address 3 -> acc 16'h1234; ADD address 3 -> acc 16'h2468; RdRam=0 -> mem_rdata 0.
- Same cycle WrRam and WrAcc (acc=9, LDI 1, address 4) -> dmem[4]=9, acc=1; address 1024 with DMEM_DEPTH=1024 -> write dropped, mem_rdata 0.
- Overflow (BIP_FLAGS_EN): acc=16'h7FFF, ADDI 1 -> acc 16'h8000, flag_v=1, flag_n=1; then SUBI 0 with acc 0 -> flag_z=1, flag_v=0.
